proc_seq_ctrl: RTL and testbench
================================

Name: proc_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the gate-level processor datapath.
- Drives the LOAD strobes of the PC and IR 32-bit registers.
- Drives the read/write enables of the decoder-addressed register file and the memory read/write requests.
- Handshakes with memory, counts retired instructions, and stops on a halt request or a memory timeout.

Parameters:
TIMEOUT, 15, consecutive cycles with MEM_READY low in FETCH or MEM before a memory error is declared (range 1..255).

Ports:
CLK  input  1  clock; all state changes on the rising edge
RESET  input  1  synchronous, active-low reset
HALT  input  1  stop request; sampled only in WB
MEM_READY  input  1  memory access complete; sampled only in FETCH and MEM
OPCODE  input  6  IR[31:26]; environment holds it stable from DECODE through WB
STATE  output  5  one-hot: bit0 FETCH, bit1 DECODE, bit2 EXE, bit3 MEM, bit4 WB; 0 in IDLE and HALTED
IR_LOAD  output  1  IR register load strobe
PC_LOAD  output  1  PC register load strobe
RF_READ  output  1  register file read enable
RF_WRITE  output  1  register file write enable
MEM_READ  output  1  memory read request
MEM_WRITE  output  1  memory write request
HALTED  output  1  sequencer stopped
MEM_ERR  output  1  sticky memory-timeout flag
INSTR_CNT  output  32  retired-instruction count

Behaviour:
Reset:
- RESET=0 at a rising CLK edge forces IDLE, whatever the current state, including mid-FETCH or mid-MEM.
- Reset values: STATE=0, every strobe 0, HALTED=0, MEM_ERR=0, INSTR_CNT=0, wait counter=0.
- Strobes are low from the cycle after that edge.

Output timing:
- All outputs decode from registered state (Moore).
- Exception: IR_LOAD = FETCH & MEM_READY, combinational, so the IR captures memory data on the same edge that the FSM leaves FETCH.

State sequence:
- IDLE: 1 cycle, then FETCH.
- FETCH: MEM_READ=1. Stay while MEM_READY=0. When MEM_READY=1, go to DECODE.
- DECODE: RF_READ=1. 1 cycle, then EXE.
- EXE: 1 cycle. If OPCODE is LW (0x23) or SW (0x2B), go to MEM; else go to WB.
- MEM:
  - OPCODE 0x23: MEM_READ=1.
  - OPCODE 0x2B: MEM_WRITE=1.
  - Stay while MEM_READY=0; when MEM_READY=1, go to WB.
- WB:
  - PC_LOAD=1.
  - RF_WRITE=1 except for SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02.
  - INSTR_CNT increments by 1 on exit from WB; it wraps from 0xFFFFFFFF to 0.
  - If HALT=1, go to HALTED; else go to FETCH.
- HALTED: HALTED=1, every strobe 0. Held until RESET.

Minimum latency:
- 4 cycles per non-memory instruction (FETCH, DECODE, EXE, WB).
- 5 cycles for LW/SW.

Timeout:
- The wait counter increments on each FETCH or MEM cycle with MEM_READY=0.
- It clears on any state transition.
- On the TIMEOUT-th consecutive waiting cycle, set MEM_ERR and go to HALTED. The instruction is not counted.
- If MEM_READY=1 in that same cycle, the handshake wins and there is no error.

Ignored inputs:
- HALT outside WB.
- MEM_READY outside FETCH and MEM.
- OPCODE outside EXE, MEM and WB.

Decomposition:
Shared package holds:
- state encodings (IDLE=0 plus the five one-hot codes);
- opcode constants LW, SW, BEQ, BNE, J;
- the TIMEOUT default.

One sub-module, instr_counter32: a 32-bit register with increment enable and synchronous active-low clear. It is built on the existing 32-bit register and ripple adder primitives.

Test Plan:
1. Reset and startup: RESET=0 for 3 cycles -> STATE=0, all strobes 0, INSTR_CNT=0. Release RESET -> one IDLE cycle, then STATE=5'b00001 with MEM_READ=1.
2. R-type instruction: OPCODE=0x00, MEM_READY=1 throughout -> STATE visits 00001, 00010, 00100, 10000 on consecutive cycles. IR_LOAD=1 in the FETCH cycle; RF_WRITE=1 and PC_LOAD=1 in WB; INSTR_CNT=1 afterwards.
3. Slow load: OPCODE=0x23, MEM_READY low for 3 MEM cycles, then high -> MEM lasts 4 cycles with MEM_READ=1, then WB with RF_WRITE=1.
4. Store: OPCODE=0x2B -> MEM_WRITE=1 in MEM, MEM_READ=0; in WB, RF_WRITE=0 and PC_LOAD=1. Repeat with OPCODE=0x04 -> MEM skipped, RF_WRITE=0 in WB.
5. Memory timeout: MEM_READY held 0 in FETCH for 15 cycles -> MEM_ERR=1, HALTED=1, STATE=0, INSTR_CNT unchanged.
6. Halt and mid-operation reset: HALT=1 in WB -> HALTED=1 the next cycle and INSTR_CNT incremented. Separately, RESET=0 during MEM with MEM_WRITE=1 -> the next cycle shows all reset values.

Source files
------------

// File: rtl/proc_seq_ctrl_pkg.sv
// Shared encodings for the instruction sequencer: state codes, opcodes, timeout default.
package proc_seq_ctrl_pkg;

   // IDLE is all-zero; the five active phases are one-hot so STATE can be driven straight from the register
   typedef enum logic [4:0] {
      S_IDLE   = 5'b00000,
      S_FETCH  = 5'b00001,
      S_DECODE = 5'b00010,
      S_EXE    = 5'b00100,
      S_MEM    = 5'b01000,
      S_WB     = 5'b10000
   } state_t;

   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_J   = 6'h02;

   localparam int TIMEOUT_DEF = 15;

   // loads and stores need the extra MEM phase
   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

   // stores, branches and jumps produce no register result
   function automatic logic writes_rf(input logic [5:0] op);
      return !((op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J));
   endfunction

endpackage

// File: rtl/proc_seq_ctrl_instr_counter32.sv
// 32-bit retired-instruction counter: register plus +1 ripple adder, wraps naturally.
module instr_counter32 (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        en,
   output logic [31:0] q
);

   logic [31:0] sum;
   logic [31:0] carry;

   assign carry[0] = 1'b1;

   // half-adder chain adding the constant 1
   for (genvar i = 0; i < 32; i++) begin : g_rca
      assign sum[i] = q[i] ^ carry[i];
      if (i < 31) begin : g_c
         assign carry[i+1] = q[i] & carry[i];
      end
   end

   // register with synchronous clear taking priority over increment
   always_ff @(posedge clk) begin
      if (!clr_n)  q <= '0;
      else if (en) q <= sum;
   end

endmodule

// File: rtl/proc_seq_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXE/[MEM]/WB with memory handshake, timeout and halt.
module proc_seq_ctrl
   import proc_seq_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        HALT,
   input  logic        MEM_READY,
   input  logic [5:0]  OPCODE,
   output logic [4:0]  STATE,
   output logic        IR_LOAD,
   output logic        PC_LOAD,
   output logic        RF_READ,
   output logic        RF_WRITE,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic        HALTED,
   output logic        MEM_ERR,
   output logic [31:0] INSTR_CNT
);

   state_t     state, nxt;
   logic [7:0] wcnt;
   logic       waiting;
   logic       tmo;

   assign STATE   = state;
   // IR must capture on the same edge FETCH completes, so this one strobe is not registered
   assign IR_LOAD = (state == S_FETCH) && MEM_READY;

   // next-state selection, including the memory-timeout exit
   always_comb begin
      nxt     = state;
      tmo     = 1'b0;
      waiting = ((state == S_FETCH) || (state == S_MEM)) && !MEM_READY;
      case (state)
         S_IDLE:   if (!HALTED) nxt = S_FETCH;
         S_FETCH: begin
            if (MEM_READY) nxt = S_DECODE;
            else if (wcnt == 8'(TIMEOUT - 1)) begin
               nxt = S_IDLE;
               tmo = 1'b1;
            end
         end
         S_DECODE: nxt = S_EXE;
         S_EXE:    nxt = is_mem_op(OPCODE) ? S_MEM : S_WB;
         S_MEM: begin
            if (MEM_READY) nxt = S_WB;
            else if (wcnt == 8'(TIMEOUT - 1)) begin
               nxt = S_IDLE;
               tmo = 1'b1;
            end
         end
         S_WB:     nxt = HALT ? S_IDLE : S_FETCH;
         default:  nxt = S_IDLE;
      endcase
   end

   // state, wait counter and strobes; strobes are decoded from the state being entered
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state     <= S_IDLE;
         wcnt      <= '0;
         HALTED    <= 1'b0;
         MEM_ERR   <= 1'b0;
         PC_LOAD   <= 1'b0;
         RF_READ   <= 1'b0;
         RF_WRITE  <= 1'b0;
         MEM_READ  <= 1'b0;
         MEM_WRITE <= 1'b0;
      end else begin
         state     <= nxt;
         wcnt      <= (nxt != state) ? '0 : (waiting ? wcnt + 8'd1 : wcnt);
         HALTED    <= HALTED | tmo | ((state == S_WB) && HALT);
         MEM_ERR   <= MEM_ERR | tmo;
         MEM_READ  <= (nxt == S_FETCH) || ((nxt == S_MEM) && (OPCODE == OP_LW));
         MEM_WRITE <= (nxt == S_MEM) && (OPCODE == OP_SW);
         RF_READ   <= (nxt == S_DECODE);
         PC_LOAD   <= (nxt == S_WB);
         RF_WRITE  <= (nxt == S_WB) && writes_rf(OPCODE);
      end
   end

   // WB always lasts exactly one cycle, so counting WB cycles counts retirements
   instr_counter32 u_cnt (
      .clk   (CLK),
      .clr_n (RESET),
      .en    (state == S_WB),
      .q     (INSTR_CNT)
   );

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Randomized bench for proc_seq_ctrl against an instruction-level trace model.
module tb_proc_seq_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        HALT = 1'b0;
   logic        MEM_READY = 1'b0;
   logic [5:0]  OPCODE = 6'h00;
   logic [4:0]  STATE;
   logic        IR_LOAD, PC_LOAD, RF_READ, RF_WRITE, MEM_READ, MEM_WRITE, HALTED, MEM_ERR;
   logic [31:0] INSTR_CNT;

   int vectors = 0;
   int miscompares = 0;

   // {STATE, IR_LOAD, PC_LOAD, RF_READ, RF_WRITE, MEM_READ, MEM_WRITE, HALTED, MEM_ERR, INSTR_CNT}
   typedef logic [44:0] ov_t;
   ov_t         obs_q[$];
   ov_t         exp_q[$];
   logic [31:0] m_cnt = 0;

   proc_seq_ctrl #(.TIMEOUT(15)) dut (
      .CLK(CLK), .RESET(RESET), .HALT(HALT), .MEM_READY(MEM_READY), .OPCODE(OPCODE),
      .STATE(STATE), .IR_LOAD(IR_LOAD), .PC_LOAD(PC_LOAD), .RF_READ(RF_READ),
      .RF_WRITE(RF_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .HALTED(HALTED), .MEM_ERR(MEM_ERR), .INSTR_CNT(INSTR_CNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   function automatic ov_t mk(logic [4:0] st, bit ir, bit pc, bit rr, bit rw, bit mr, bit mw,
                              bit hl, bit er, logic [31:0] c);
      return {st, ir, pc, rr, rw, mr, mw, hl, er, c};
   endfunction

   function automatic ov_t sample();
      return {STATE, IR_LOAD, PC_LOAD, RF_READ, RF_WRITE, MEM_READ, MEM_WRITE, HALTED, MEM_ERR, INSTR_CNT};
   endfunction

   function automatic bit rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // sample this cycle's outputs, then move to just after the next rising edge
   task automatic tick();
      #1;
      obs_q.push_back(sample());
      @(posedge CLK);
      #1;
   endtask

   // reference: expected per-cycle trace of one instruction from its phase lengths
   task automatic model_instr(input logic [5:0] op, input int fw, input int mw, input bit halt);
      bit is_mem = (op == 6'h23) || (op == 6'h2B);
      bit wr     = !(op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02);
      for (int i = 0; i < fw; i++) exp_q.push_back(mk(5'd1, 0, 0, 0, 0, 1, 0, 0, 0, m_cnt));
      exp_q.push_back(mk(5'd1, 1, 0, 0, 0, 1, 0, 0, 0, m_cnt));
      exp_q.push_back(mk(5'd2, 0, 0, 1, 0, 0, 0, 0, 0, m_cnt));
      exp_q.push_back(mk(5'd4, 0, 0, 0, 0, 0, 0, 0, 0, m_cnt));
      if (is_mem)
         for (int i = 0; i <= mw; i++)
            exp_q.push_back(mk(5'd8, 0, 0, 0, 0, op == 6'h23, op == 6'h2B, 0, 0, m_cnt));
      exp_q.push_back(mk(5'd16, 0, 1, 0, wr, 0, 0, 0, 0, m_cnt));
      m_cnt = m_cnt + 1;
      if (halt) exp_q.push_back(mk(5'd0, 0, 0, 0, 0, 0, 0, 1, 0, m_cnt));
   endtask

   // stimulus: starts in FETCH; ignored inputs are randomized in every phase that should ignore them
   task automatic exec_instr(input logic [5:0] op, input int fw, input int mw, input bit halt);
      for (int i = 0; i < fw; i++) begin
         MEM_READY = 0; HALT = rnd(); OPCODE = 6'($urandom); tick();
      end
      MEM_READY = 1; HALT = rnd(); OPCODE = 6'($urandom); tick();
      OPCODE = op; MEM_READY = rnd(); HALT = rnd(); tick();
      MEM_READY = rnd(); HALT = rnd(); tick();
      if (op == 6'h23 || op == 6'h2B) begin
         for (int i = 0; i < mw; i++) begin
            MEM_READY = 0; HALT = rnd(); tick();
         end
         MEM_READY = 1; HALT = rnd(); tick();
      end
      MEM_READY = rnd(); HALT = halt; tick();
      HALT = 0;
      if (halt) begin
         MEM_READY = rnd(); tick();
      end
   endtask

   task automatic restart();
      RESET = 0; @(posedge CLK); #1;
      RESET = 1; @(posedge CLK); #1;
      m_cnt = 0;
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset();
      MEM_READY = 0; HALT = 0;
      for (int i = 0; i < 3; i++) begin
         HALT = rnd(); MEM_READY = rnd();
         @(posedge CLK); #1;
         vectors++;
         if (sample() !== 45'd0) begin
            miscompares++;
            $display("FAIL reset cyc %0d: got %h want 0", i, sample());
         end
      end
      RESET = 1; HALT = 0; MEM_READY = 0;
      #1; vectors++;
      if (sample() !== 45'd0) begin
         miscompares++;
         $display("FAIL idle: got %h want 0", sample());
      end
      @(posedge CLK); #1;
      vectors++;
      if (sample() !== mk(5'd1, 0, 0, 0, 0, 1, 0, 0, 0, 0)) begin
         miscompares++;
         $display("FAIL first_fetch: got %h want %h", sample(), mk(5'd1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
   endtask

   task automatic test_rtype();
      obs_q.delete(); exp_q.delete();
      exec_instr(6'h00, 0, 0, 0); model_instr(6'h00, 0, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rtype cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_slow_load();
      obs_q.delete(); exp_q.delete();
      exec_instr(6'h23, 1, 3, 0); model_instr(6'h23, 1, 3, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL slow_load cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_store_branch();
      logic [5:0] ops [4] = '{6'h2B, 6'h04, 6'h05, 6'h02};
      obs_q.delete(); exp_q.delete();
      foreach (ops[k]) begin
         exec_instr(ops[k], 0, k, 0); model_instr(ops[k], 0, k, 0);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL store_branch cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] pool [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
      obs_q.delete(); exp_q.delete();
      for (int n = 0; n < 24; n++) begin
         logic [5:0] op = (n == 23) ? 6'($urandom) : pool[$urandom_range(0, 6)];
         int fw = (n == 5) ? 14 : int'($urandom_range(0, 4));
         int mw = (n == 9) ? 14 : int'($urandom_range(0, 4));
         if (n == 9) op = 6'h23;
         exec_instr(op, fw, mw, 0); model_instr(op, fw, mw, 0);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL random cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_halt();
      obs_q.delete(); exp_q.delete();
      exec_instr(6'h00, 1, 0, 1); model_instr(6'h00, 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         MEM_READY = rnd(); HALT = rnd(); OPCODE = 6'($urandom); tick();
         exp_q.push_back(mk(5'd0, 0, 0, 0, 0, 0, 0, 1, 0, m_cnt));
      end
      HALT = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL halt cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      restart();
      exec_instr(6'h00, 0, 0, 0);
      MEM_READY = 1; tick();
      OPCODE = 6'h2B; MEM_READY = 0; tick();
      tick();
      #1; vectors++;
      if (sample() !== mk(5'd8, 0, 0, 0, 0, 0, 1, 0, 0, 1)) begin
         miscompares++;
         $display("FAIL mid_mem: got %h want %h", sample(), mk(5'd8, 0, 0, 0, 0, 0, 1, 0, 0, 1));
      end
      RESET = 0; @(posedge CLK); #1;
      vectors++;
      if (sample() !== 45'd0) begin
         miscompares++;
         $display("FAIL mid_reset: got %h want 0", sample());
      end
      RESET = 1; @(posedge CLK); #1;
      vectors++;
      if (sample() !== mk(5'd1, 0, 0, 0, 0, 1, 0, 0, 0, 0)) begin
         miscompares++;
         $display("FAIL post_reset_fetch: got %h want %h", sample(), mk(5'd1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
   endtask

   task automatic test_timeout();
      // FETCH timeout after one retired instruction
      restart();
      exec_instr(6'h00, 0, 0, 0); model_instr(6'h00, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         MEM_READY = 0; tick();
         exp_q.push_back(mk(5'd1, 0, 0, 0, 0, 1, 0, 0, 0, m_cnt));
      end
      for (int i = 0; i < 3; i++) begin
         MEM_READY = rnd(); HALT = rnd(); tick();
         exp_q.push_back(mk(5'd0, 0, 0, 0, 0, 0, 0, 1, 1, m_cnt));
      end
      HALT = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL fetch_timeout cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      // MEM timeout during a load
      restart();
      MEM_READY = 1; tick();
      OPCODE = 6'h23; MEM_READY = 0; tick();
      tick();
      exp_q.push_back(mk(5'd1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
      exp_q.push_back(mk(5'd2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(5'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 15; i++) begin
         MEM_READY = 0; tick();
         exp_q.push_back(mk(5'd8, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      MEM_READY = 1; tick();
      exp_q.push_back(mk(5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL mem_timeout cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_slow_load();
      test_store_branch();
      test_random();
      test_halt();
      test_mid_reset();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
